// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants for the fetch stage and instruction memory
package cpu_pkg;
  localparam int          INS_W     = 32;
  localparam logic [31:0] NOP_INS   = 32'h0;
  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam int          ROM_DEPTH = 82;
endpackage

// File: rtl/pc_unit.sv
// pc_unit: program counter with sequential wrap, redirect range check and sticky fault
module pc_unit #(
  parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
  parameter int          ROM_DEPTH = cpu_pkg::ROM_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic        fault
);
  localparam logic [31:0] LAST = 32'(ROM_DEPTH - 1);
  logic oob;
  logic [31:0] seq_pc;
  assign oob    = redirect_pc > LAST;
  assign seq_pc = (pc == LAST) ? 32'h0 : pc + 32'h1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else if (redirect) begin
      pc    <= oob ? 32'h0 : redirect_pc;
      fault <= fault | oob;
    end else if (!stall) begin
      pc    <= seq_pc;
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC drive to instruction ROM, IF/ID pipeline register and delivered-instruction counter
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
  parameter int          ROM_DEPTH = cpu_pkg::ROM_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Stall,
  input  logic                      Redirect,
  input  logic [31:0]               RedirectPc,
  input  logic [cpu_pkg::INS_W-1:0] InsIn,
  output logic [31:0]               PcOut,
  output logic [cpu_pkg::INS_W-1:0] IfIdIns,
  output logic [31:0]               IfIdPc,
  output logic [31:0]               IfIdPcPlus1,
  output logic                      IfIdValid,
  output logic                      FetchFault,
  output logic [31:0]               FetchCount
);
  import cpu_pkg::*;
  logic [31:0] pc;
  pc_unit #(.RESET_PC(RESET_PC), .ROM_DEPTH(ROM_DEPTH)) u_pc (
    .clk(clk), .rst(rst), .stall(Stall), .redirect(Redirect),
    .redirect_pc(RedirectPc), .pc(pc), .fault(FetchFault)
  );
  assign PcOut = pc;
  // a redirect squashes the word in flight but keeps the last real PC pair for debug
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      IfIdIns     <= NOP_INS;
      IfIdPc      <= 32'h0;
      IfIdPcPlus1 <= 32'h0;
      IfIdValid   <= 1'b0;
      FetchCount  <= 32'h0;
    end else if (Redirect) begin
      IfIdIns     <= NOP_INS;
      IfIdValid   <= 1'b0;
    end else if (!Stall) begin
      IfIdIns     <= InsIn;
      IfIdPc      <= pc;
      IfIdPcPlus1 <= pc + 32'h1;
      IfIdValid   <= 1'b1;
      FetchCount  <= (&FetchCount) ? FetchCount : FetchCount + 32'h1;
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized and directed checks of fetch_stage against a behavioural model
module tb_fetch_stage;
  localparam int DEPTH = 82;
  logic clk = 0, rst = 1, Stall = 0, Redirect = 0;
  logic [31:0] RedirectPc = 0, InsIn, PcOut, IfIdIns, IfIdPc, IfIdPcPlus1, FetchCount;
  logic IfIdValid, FetchFault;
  logic [31:0] rom [DEPTH];
  int checks = 0, failures = 0;
  logic [31:0] m_pc, m_ins, m_ipc, m_ip1, m_cnt;
  logic m_valid, m_fault;

  always #5 clk = ~clk;
  assign InsIn = (PcOut < DEPTH) ? rom[PcOut] : 32'hdead_beef;

  fetch_stage dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Redirect(Redirect), .RedirectPc(RedirectPc),
    .InsIn(InsIn), .PcOut(PcOut), .IfIdIns(IfIdIns), .IfIdPc(IfIdPc),
    .IfIdPcPlus1(IfIdPcPlus1), .IfIdValid(IfIdValid), .FetchFault(FetchFault),
    .FetchCount(FetchCount)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, PcOut, m_pc);
    chk({tag, ".ins"}, IfIdIns, m_ins);
    chk({tag, ".ifpc"}, IfIdPc, m_ipc);
    chk({tag, ".ifpc1"}, IfIdPcPlus1, m_ip1);
    chk({tag, ".valid"}, {31'b0, IfIdValid}, {31'b0, m_valid});
    chk({tag, ".fault"}, {31'b0, FetchFault}, {31'b0, m_fault});
    chk({tag, ".count"}, FetchCount, m_cnt);
  endtask

  task automatic model_reset();
    m_pc = 0; m_ins = 0; m_ipc = 0; m_ip1 = 0; m_cnt = 0; m_valid = 0; m_fault = 0;
  endtask

  task automatic step(input string tag, input logic s, input logic r, input logic [31:0] t);
    Stall = s; Redirect = r; RedirectPc = t;
    @(posedge clk);
    if (r) begin
      m_fault = m_fault | (t >= DEPTH);
      m_pc = (t >= DEPTH) ? 0 : t;
      m_ins = 0;
      m_valid = 0;
    end else if (!s) begin
      m_ins = rom[m_pc];
      m_ipc = m_pc;
      m_ip1 = m_pc + 1;
      m_valid = 1;
      m_cnt = (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 1;
      m_pc = (m_pc + 1) % DEPTH;
    end
    #1;
    Stall = 0; Redirect = 0;
    check_all(tag);
  endtask

  task automatic advance_to(input logic [31:0] target);
    for (int i = 0; i < 2 * DEPTH && m_pc != target; i++) step("adv", 0, 0, 0);
    chk("advance_to", PcOut, target);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
    rom[0] = 32'h0000_0f0e;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk); #1;
    rst = 0;
    step("first", 0, 0, 0);
    chk("first.ins_const", IfIdIns, 32'h0000_0f0e);
    chk("first.pc_const", PcOut, 32'd1);
    advance_to(5);
    for (int i = 0; i < 3; i++) step("stall", 1, 0, 0);
    step("stall_rel", 0, 0, 0);
    chk("stall_rel.ins", IfIdIns, rom[5]);
    advance_to(9);
    step("redir", 0, 1, 12);
    chk("redir.pc_const", PcOut, 32'd12);
    step("redir_tgt", 0, 0, 0);
    chk("redir_tgt.pc1_const", IfIdPcPlus1, 32'd13);
    step("rs", 1, 1, 20);
    step("rs_hold", 1, 0, 0);
    step("rs_rel", 0, 0, 0);
    chk("rs_rel.ins", IfIdIns, rom[20]);
    step("to81", 0, 1, 81);
    step("wrap", 0, 0, 0);
    chk("wrap.pc_const", PcOut, 32'd0);
    step("oob", 0, 1, 100);
    chk("oob.fault_const", {31'b0, FetchFault}, 32'd1);
    for (int i = 0; i < 4; i++) step("sticky", i[0], 0, 0);
    step("stall", 1, 0, 0);
    #2;
    rst = 1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk); #1;
    check_all("rst_hold");
    rst = 0;
    step("resume", 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic s, r;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 6) == 0);
      step("rand", s, r, $urandom_range(0, 99));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined CPU, sitting directly upstream of the instruction memory and feeding the decode stage. Holds the program counter, drives the word address into the combinational instruction ROM, and captures the returned instruction into the IF/ID pipeline register. Handles hazard-unit stalls and branch/jump redirects, and keeps a fetch fault flag and a delivered-instruction counter for debug.

## Interface
- RESET_PC, 0: word address loaded into the PC on reset.
- ROM_DEPTH, 82: number of instruction words; valid addresses are 0..ROM_DEPTH-1.
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- Stall  input  1  from the hazard unit; holds the PC and IF/ID register.
- Redirect  input  1  from execute; branch taken or jump, loads RedirectPc.
- RedirectPc  input  32  word-address target of the redirect.
- InsIn  input  32  instruction word returned by the instruction memory.
- PcOut  output  32  current PC, a word address sent to the instruction memory.
- IfIdIns  output  32  latched instruction for decode.
- IfIdPc  output  32  PC of the latched instruction.
- IfIdPcPlus1  output  32  IfIdPc+1, the link/fall-through address.
- IfIdValid  output  1  latched instruction is real; 0 means bubble.
- FetchFault  output  1  sticky flag: a redirect target was out of range.
- FetchCount  output  32  count of valid instructions delivered to decode.

## Operation
- PC is a word address. Sequential next PC is PC+1. When PC = ROM_DEPTH-1, the next sequential PC wraps to 0.
- Per-edge priority, highest first:
  - rst
  - Redirect
  - Stall
  - normal advance
- Redirect, regardless of Stall:
  - PC <= RedirectPc.
  - IfIdIns <= 32'h0 (NOP), IfIdValid <= 0.
  - IfIdPc and IfIdPcPlus1 hold their values.
  - If RedirectPc >= ROM_DEPTH: PC <= 0 and FetchFault <= 1.
- Stall without Redirect: PC and all IfId* outputs hold, and FetchCount holds.
- Normal advance:
  - IfIdIns <= InsIn, IfIdPc <= PC, IfIdPcPlus1 <= PC+1 (full 32-bit add, no wrap), IfIdValid <= 1.
  - PC <= next sequential PC.
  - FetchCount increments, saturating at 32'hFFFFFFFF.
- FetchFault is sticky. Only rst clears it.
- No decoding of instruction contents. Halting is decode's responsibility.

## Timing
- PcOut is driven directly from the PC register, with no combinational path from any input. InsIn is expected to be combinationally valid in the same cycle.
- Latency: the instruction at PC appears on IfIdIns one edge after PC is presented on PcOut.
- Reset (asynchronous assert, values visible immediately):
  - PC = RESET_PC.
  - IfIdIns = 0, IfIdPc = 0, IfIdPcPlus1 = 0, IfIdValid = 0.
  - FetchFault = 0, FetchCount = 0.
- After rst deasserts, the first edge latches the word at RESET_PC with IfIdValid = 1.
- Redirect is single-cycle. Exactly one bubble follows it into decode, and the target instruction is latched on the next non-stalled edge.
- Redirect and Stall in the same cycle: redirect applies and a bubble is inserted. If Stall persists on the next edge, the bubble holds.
- rst mid-stall or mid-redirect discards all pending state. No redirect is remembered across reset.

## Structure
- Shared package `cpu_pkg`, which owns:
  - INS_W = 32.
  - NOP_INS = 32'h0.
  - The default RESET_PC.
  - ROM_DEPTH, shared with the instruction memory.
- One sub-module, `pc_unit`, holds the PC register, next-PC selection, wrap and range check, and FetchFault. The top level holds the IF/ID register and FetchCount.

## Test plan
- Reset release with RESET_PC = 0 and ROM[0] = 32'h00000f0e, no stall: after edge 1, IfIdIns = 00000f0e, IfIdPc = 0, IfIdValid = 1, PcOut = 1, FetchCount = 1.
- Stall held 3 cycles at PC = 5: PcOut stays 5, IfId* unchanged, and FetchCount does not change. On release, the next edge latches ROM[5].
- Redirect to 12 while PC = 9: the next edge gives PcOut = 12, IfIdValid = 0, IfIdIns = 0. The following edge gives IfIdIns = ROM[12], IfIdPc = 12, IfIdPcPlus1 = 13.
- Redirect and Stall together to 20: PcOut = 20 and a bubble is inserted. While Stall stays high, the bubble holds; after release, ROM[20] is latched.
- Wrap and fault with ROM_DEPTH = 82:
  - Sequential fetch at PC = 81 gives next PcOut = 0 and FetchFault = 0.
  - Redirect to 100 gives PcOut = 0 and FetchFault = 1, and FetchFault persists until rst.
- Asynchronous rst mid-run, asserted between edges: outputs go to reset values immediately, and fetch resumes from RESET_PC after release.
